bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/timer_pkg.sv | 33 +++
 rtl/bcd_digit_counter.sv | 51 +++++
 rtl/bcd_countdown_timer.sv | 166 ++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and elaboration helpers for the BCD countdown timer.
package timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StExpired
  } timer_state_t;

  localparam bcd_digit_t BcdMax = 4'd9;

  // Clocks per tick: 1 s / (clock period * 10^frac_digits), evaluated at elaboration.
  function automatic int calc_tick_cnt(input int clk_period_ns, input int frac_digits);
    longint unsigned denom;
    denom = longint'(clk_period_ns);
    for (int i = 0; i < frac_digits; i++) begin
      denom = denom * 64'd10;
    end
    if (denom == 64'd0) begin
      return 1;
    end
    return int'(64'd1_000_000_000 / denom);
  endfunction

  // Out-of-range BCD digits clamp to 9.
  function automatic bcd_digit_t sat_digit(input bcd_digit_t d);
    return (d > BcdMax) ? BcdMax : d;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: synchronous load, up/down step gated by ripple carry/borrow.
module bcd_digit_counter
  import timer_pkg::*;
#(
  parameter logic [3:0] RESET_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_step,
  input  logic       i_up,
  input  logic       i_cin,
  output logic       o_cout,
  output logic [3:0] o_next,
  output logic [3:0] o_digit
);

  bcd_digit_t r_digit;
  bcd_digit_t w_next;
  logic       w_at_edge;

  // Next digit value when stepping; at 9 (up) or 0 (down) the digit wraps and ripples
  always_comb begin
    w_at_edge = i_up ? (r_digit == BcdMax) : (r_digit == 4'd0);
    w_next    = r_digit;
    if (i_cin) begin
      if (w_at_edge) begin
        w_next = i_up ? 4'd0 : BcdMax;
      end else begin
        w_next = i_up ? (r_digit + 4'd1) : (r_digit - 4'd1);
      end
    end
  end

  assign o_cout  = i_cin & w_at_edge;
  assign o_next  = w_next;
  assign o_digit = r_digit;

  // Digit register: load beats step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit <= RESET_VAL;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_step) begin
      r_digit <= w_next;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD up/down timer with prescaler, pause, wrap/stop terminal handling and warning flag.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int                    NUM_DIGITS    = 8,
  parameter int                    FRAC_DIGITS   = 2,
  parameter int                    CLK_PERIOD_NS = 10,
  parameter int                    TICK_CNT      = calc_tick_cnt(CLK_PERIOD_NS, FRAC_DIGITS),
  parameter logic [4*NUM_DIGITS-1:0] PRESET      = (4*NUM_DIGITS)'(32'h0001_2000),
  parameter bit                    WRAP          = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    count_up,
  input  logic [4*NUM_DIGITS-1:0] warn_value,
  output logic [3:0]              display_digit [NUM_DIGITS],
  output logic                    timer_expires,
  output logic                    expire_pulse,
  output logic                    warning,
  output logic                    running
);

  localparam int                    PRESC_W    = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICK_CNT - 1);
  localparam logic [4*NUM_DIGITS-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  timer_state_t             r_state, w_state_next;
  logic [PRESC_W-1:0]       r_presc, w_presc_next;
  logic                     r_expires, w_expires_next;
  logic                     r_pulse, w_pulse_next;
  logic                     w_reload, w_step;
  logic [4*NUM_DIGITS-1:0]  w_reload_val, w_load_sat;
  logic [4*NUM_DIGITS-1:0]  w_count, w_count_next;
  logic [3:0]               w_digit [NUM_DIGITS];
  logic [3:0]               w_digit_next [NUM_DIGITS];
  logic [NUM_DIGITS:0]      w_carry;
  logic                     w_term_now, w_term_next;

  // Clamp each incoming load digit into 0..9
  always_comb begin
    w_load_sat = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_load_sat[4*i +: 4] = sat_digit(load_value[4*i +: 4]);
    end
  end

  // Digit 0 always steps on a tick; higher digits step only when everything below wraps
  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_counter #(
      .RESET_VAL (PRESET[4*g +: 4])
    ) u_digit (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_reload),
      .i_load_val (w_reload_val[4*g +: 4]),
      .i_step     (w_step),
      .i_up       (count_up),
      .i_cin      (w_carry[g]),
      .o_cout     (w_carry[g+1]),
      .o_next     (w_digit_next[g]),
      .o_digit    (w_digit[g])
    );
    assign display_digit[g] = w_digit[g];
  end

  // Flatten digits for terminal detection and threshold compare
  always_comb begin
    w_count      = '0;
    w_count_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_count[4*i +: 4]      = w_digit[i];
      w_count_next[4*i +: 4] = w_digit_next[i];
    end
  end

  // A full ripple through every digit means the count already sits at the terminal value
  assign w_term_now  = w_carry[NUM_DIGITS];
  assign w_term_next = count_up ? (w_count_next == ALL_NINES) : (w_count_next == '0);

  // Next-state: clear > load > FSM; the prescaler only advances while running and enabled
  always_comb begin
    w_state_next   = r_state;
    w_presc_next   = r_presc;
    w_expires_next = r_expires;
    w_pulse_next   = 1'b0;
    w_reload       = 1'b0;
    w_reload_val   = PRESET;
    w_step         = 1'b0;
    if (clear) begin
      w_state_next   = StIdle;
      w_presc_next   = '0;
      w_expires_next = 1'b0;
      w_reload       = 1'b1;
    end else if (load) begin
      w_state_next   = StIdle;
      w_presc_next   = '0;
      w_expires_next = 1'b0;
      w_reload       = 1'b1;
      w_reload_val   = w_load_sat;
    end else begin
      unique case (r_state)
        StIdle, StPause: begin
          if (enable) begin
            w_state_next = StRun;
          end
        end
        StRun: begin
          if (!WRAP && w_term_now) begin
            // Started on the terminal value: expire without waiting for a tick
            w_state_next   = StExpired;
            w_expires_next = 1'b1;
            w_pulse_next   = 1'b1;
          end else if (!enable) begin
            w_state_next = StPause;
          end else if (r_presc == PRESC_LAST) begin
            w_presc_next = '0;
            w_step       = 1'b1;
            if (w_term_next) begin
              w_pulse_next = 1'b1;
              if (!WRAP) begin
                w_state_next   = StExpired;
                w_expires_next = 1'b1;
              end
            end
          end else begin
            w_presc_next = r_presc + PRESC_W'(1);
          end
        end
        StExpired: begin
          w_state_next = StExpired;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  // Control registers; reset aborts any pending tick or pulse immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_presc   <= '0;
      r_expires <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_presc   <= w_presc_next;
      r_expires <= w_expires_next;
      r_pulse   <= w_pulse_next;
    end
  end

  assign running       = (r_state == StRun);
  assign timer_expires = r_expires;
  assign expire_pulse  = r_pulse;
  // Digits are always 0..9, so a packed unsigned compare equals the decimal compare
  assign warning       = !count_up && (w_count <= warn_value);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench: directed scenarios plus randomized run against a decimal reference model.
module tb_bcd_countdown_timer;

  localparam int          ND      = 8;
  localparam int          TC      = 4;
  localparam logic [31:0] PRESET0 = 32'h0000_0003;
  localparam logic [31:0] PRESET1 = 32'h0001_2000;
  localparam int          MStop   = 0;
  localparam int          MRun    = 1;
  localparam int          MExp    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en0, clr0, ld0, up0;
  logic [31:0] lv0, wv0, cnt0;
  logic [3:0]  dd0 [ND];
  logic        exp0, pls0, warn0, run0;
  logic        en1, clr1, ld1, up1;
  logic [31:0] lv1, wv1, cnt1;
  logic [3:0]  dd1 [ND];
  logic        exp1, pls1, warn1, run1;

  int total = 0;
  int bad   = 0;

  // Reference model: count as a plain decimal integer, phase as cycles run toward the next tick
  int m_val, m_mode, m_phase;
  bit m_exp, m_pulse;

  bcd_countdown_timer #(
    .NUM_DIGITS (ND), .TICK_CNT (TC), .PRESET (PRESET0), .WRAP (0)
  ) dut0 (
    .clk (clk), .reset (reset), .enable (en0), .clear (clr0), .load (ld0),
    .load_value (lv0), .count_up (up0), .warn_value (wv0), .display_digit (dd0),
    .timer_expires (exp0), .expire_pulse (pls0), .warning (warn0), .running (run0)
  );

  bcd_countdown_timer #(
    .NUM_DIGITS (ND), .TICK_CNT (TC), .PRESET (PRESET1), .WRAP (1)
  ) dut1 (
    .clk (clk), .reset (reset), .enable (en1), .clear (clr1), .load (ld1),
    .load_value (lv1), .count_up (up1), .warn_value (wv1), .display_digit (dd1),
    .timer_expires (exp1), .expire_pulse (pls1), .warning (warn1), .running (run1)
  );

  always #5 clk = ~clk;

  always_comb begin
    cnt0 = '0;
    cnt1 = '0;
    for (int i = 0; i < ND; i++) begin
      cnt0[4*i +: 4] = dd0[i];
      cnt1[4*i +: 4] = dd1[i];
    end
  end

  function automatic int bcd_val(input logic [31:0] b);
    int v;
    int d;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] b;
    int r;
    r = v;
    for (int i = 0; i < ND; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  task automatic model_reset();
    m_val   = bcd_val(PRESET0);
    m_mode  = MStop;
    m_phase = 0;
    m_exp   = 1'b0;
    m_pulse = 1'b0;
  endtask

  task automatic model_step();
    int term;
    term    = up0 ? 99999999 : 0;
    m_pulse = 1'b0;
    if (clr0 || ld0) begin
      m_val   = clr0 ? bcd_val(PRESET0) : bcd_val(lv0);
      m_mode  = MStop;
      m_phase = 0;
      m_exp   = 1'b0;
    end else if (m_mode == MStop) begin
      if (en0) m_mode = MRun;
    end else if (m_mode == MRun) begin
      if (m_val == term) begin
        m_mode = MExp; m_exp = 1'b1; m_pulse = 1'b1;
      end else if (!en0) begin
        m_mode = MStop;
      end else begin
        m_phase++;
        if (m_phase == TC) begin
          m_phase = 0;
          m_val   = up0 ? m_val + 1 : m_val - 1;
          if (m_val == term) begin
            m_mode = MExp; m_exp = 1'b1; m_pulse = 1'b1;
          end
        end
      end
    end
  endtask

  // Advance one clock edge; the model sees the same inputs the DUT sampled
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    wv0 = 32'h0000_0005;
    #1;
    total++; if (cnt0 !== PRESET0) begin bad++; $display("FAIL reset_count0: got %h want %h", cnt0, PRESET0); end
    total++; if (cnt1 !== PRESET1) begin bad++; $display("FAIL reset_count1: got %h want %h", cnt1, PRESET1); end
    total++; if ({run0, exp0, pls0} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {run0, exp0, pls0}); end
    total++; if (warn0 !== 1'b1) begin bad++; $display("FAIL reset_warning: got %b want 1", warn0); end
    // Run into the count, then hit reset between edges: it must act at once
    en0 = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    total++; if (cnt0 !== 32'h2) begin bad++; $display("FAIL pre_reset_count: got %h want 2", cnt0); end
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    total++; if (cnt0 !== PRESET0) begin bad++; $display("FAIL async_reset_count: got %h want %h", cnt0, PRESET0); end
    total++; if (run0 !== 1'b0) begin bad++; $display("FAIL async_reset_running: got %b want 0", run0); end
    en0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_expire();
    int chg [4];
    int nchg;
    int npls;
    logic [31:0] prev;
    do_reset();
    en0 = 1'b1; up0 = 1'b0;
    nchg = 0; npls = 0;
    for (int i = 0; i < 40; i++) begin
      prev = cnt0;
      tick();
      total++; if (cnt0 !== to_bcd(m_val)) begin bad++; $display("FAIL expire_count: got %h want %h", cnt0, to_bcd(m_val)); end
      if (cnt0 !== prev) begin
        if (nchg < 4) chg[nchg] = i;
        nchg++;
      end
      if (pls0) npls++;
    end
    total++; if (nchg !== 3) begin bad++; $display("FAIL expire_changes: got %0d want 3", nchg); end
    if (nchg == 3) begin
      total++; if (chg[0] !== 4) begin bad++; $display("FAIL first_tick_cycle: got %0d want 4", chg[0]); end
      total++; if (chg[1] - chg[0] !== 4 || chg[2] - chg[1] !== 4) begin
        bad++; $display("FAIL tick_spacing: got %0d,%0d want 4,4", chg[1] - chg[0], chg[2] - chg[1]);
      end
    end
    total++; if (npls !== 1) begin bad++; $display("FAIL expire_pulse_count: got %0d want 1", npls); end
    total++; if ({exp0, run0, cnt0} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL expired_hold: got exp=%b run=%b cnt=%h want 1 0 0", exp0, run0, cnt0);
    end
  endtask

  task automatic test_borrow();
    int n;
    ld0 = 1'b1; lv0 = 32'h0000_0100; en0 = 1'b1; up0 = 1'b0;
    tick();
    ld0 = 1'b0;
    total++; if (cnt0 !== 32'h100) begin bad++; $display("FAIL borrow_load: got %h want 00000100", cnt0); end
    n = 0;
    while (cnt0 === 32'h100 && n < 12) begin tick(); n++; end
    total++; if (cnt0 !== 32'h99 || n !== 5) begin
      bad++; $display("FAIL borrow_tick: got %h after %0d want 00000099 after 5", cnt0, n);
    end
  endtask

  task automatic test_pause();
    int n;
    ld0 = 1'b1; lv0 = 32'h0000_0050; en0 = 1'b1; up0 = 1'b0;
    tick();
    ld0 = 1'b0;
    tick();
    total++; if (run0 !== 1'b1) begin bad++; $display("FAIL pause_start_running: got %b want 1", run0); end
    tick(); tick();
    en0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (run0 !== 1'b0 || cnt0 !== 32'h50) begin
        bad++; $display("FAIL paused: got run=%b cnt=%h want 0 00000050", run0, cnt0);
      end
    end
    en0 = 1'b1;
    tick();
    total++; if (run0 !== 1'b1) begin bad++; $display("FAIL resume_running: got %b want 1", run0); end
    n = 0;
    while (cnt0 === 32'h50 && n < 12) begin tick(); n++; end
    total++; if (n !== 2 || cnt0 !== 32'h49) begin
      bad++; $display("FAIL resume_tick: got %h after %0d want 00000049 after 2", cnt0, n);
    end
  endtask

  task automatic test_wrap();
    int n;
    int npls;
    ld1 = 1'b1; lv1 = 32'h9999_9998; en1 = 1'b1; up1 = 1'b1;
    tick();
    ld1 = 1'b0;
    total++; if (cnt1 !== 32'h9999_9998) begin bad++; $display("FAIL wrap_load: got %h want 99999998", cnt1); end
    n = 0; npls = 0;
    while (cnt1 === 32'h9999_9998 && n < 12) begin tick(); n++; if (pls1) npls++; end
    total++; if (cnt1 !== 32'h9999_9999 || pls1 !== 1'b1) begin
      bad++; $display("FAIL wrap_terminal: got %h pulse=%b want 99999999 pulse=1", cnt1, pls1);
    end
    n = 0;
    while (cnt1 === 32'h9999_9999 && n < 12) begin tick(); n++; if (pls1) npls++; end
    total++; if (cnt1 !== 32'h0 || n !== 4) begin
      bad++; $display("FAIL wrap_rollover: got %h after %0d want 00000000 after 4", cnt1, n);
    end
    total++; if (npls !== 1) begin bad++; $display("FAIL wrap_pulse_count: got %0d want 1", npls); end
    total++; if ({exp1, run1, warn1} !== 3'b010) begin
      bad++; $display("FAIL wrap_flags: got exp=%b run=%b warn=%b want 0 1 0", exp1, run1, warn1);
    end
    en1 = 1'b0;
  endtask

  task automatic test_clear_load();
    int n;
    ld0 = 1'b1; lv0 = 32'h0000_0040; en0 = 1'b1; up0 = 1'b0;
    tick();
    ld0 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    clr0 = 1'b1; ld0 = 1'b1; lv0 = 32'h0000_0500;
    tick();
    clr0 = 1'b0; ld0 = 1'b0;
    total++; if (cnt0 !== PRESET0) begin bad++; $display("FAIL clear_wins: got %h want %h", cnt0, PRESET0); end
    total++; if ({run0, exp0} !== 2'b00) begin bad++; $display("FAIL clear_idle: got run=%b exp=%b want 0 0", run0, exp0); end
    n = 0;
    while (cnt0 === PRESET0 && n < 12) begin
      tick(); n++;
      if (n == 1) begin
        total++; if (run0 !== 1'b1) begin bad++; $display("FAIL clear_then_run: got %b want 1", run0); end
      end
    end
    total++; if (n !== 5 || cnt0 !== 32'h2) begin
      bad++; $display("FAIL clear_prescaler: got %h after %0d want 00000002 after 5", cnt0, n);
    end
  endtask

  task automatic test_warning();
    int n;
    wv0 = 32'h0000_1000; up0 = 1'b0; ld0 = 1'b1; lv0 = 32'h0000_1001; en0 = 1'b1;
    tick();
    ld0 = 1'b0;
    n = 0;
    while (cnt0 === 32'h1001 && n < 12) begin
      total++; if (warn0 !== 1'b0) begin bad++; $display("FAIL warning_early: got %b want 0", warn0); end
      tick(); n++;
    end
    total++; if (cnt0 !== 32'h1000 || warn0 !== 1'b1) begin
      bad++; $display("FAIL warning_rise: got cnt=%h warn=%b want 00001000 1", cnt0, warn0);
    end
    up0 = 1'b1;
    #1;
    total++; if (warn0 !== 1'b0) begin bad++; $display("FAIL warning_upmode: got %b want 0", warn0); end
    up0 = 1'b0;
  endtask

  task automatic test_load_terminal();
    int npls;
    en0 = 1'b0; up0 = 1'b0; ld0 = 1'b1; lv0 = 32'hF0A0_0B05;
    tick();
    total++; if (cnt0 !== 32'h9090_0905) begin bad++; $display("FAIL load_saturate: got %h want 90900905", cnt0); end
    lv0 = 32'h0; en0 = 1'b1;
    tick();
    ld0 = 1'b0;
    tick();
    total++; if (run0 !== 1'b1 || pls0 !== 1'b0) begin
      bad++; $display("FAIL terminal_first_run: got run=%b pulse=%b want 1 0", run0, pls0);
    end
    npls = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (pls0) npls++; end
    total++; if (npls !== 1 || exp0 !== 1'b1 || cnt0 !== 32'h0) begin
      bad++; $display("FAIL terminal_load_expire: got pulses=%0d exp=%b cnt=%h want 1 1 0", npls, exp0, cnt0);
    end
  endtask

  task automatic test_random();
    clr0 = 1'b0; ld0 = 1'b0; en0 = 1'b0; up0 = 1'b0;
    do_reset();
    ld0 = 1'b1; lv0 = 32'h0000_0025; wv0 = 32'h0000_0010; en0 = 1'b1;
    for (int i = 0; i < 700; i++) begin
      tick();
      total++; if (cnt0 !== to_bcd(m_val)) begin bad++; $display("FAIL rand_count: got %h want %h", cnt0, to_bcd(m_val)); end
      total++; if (run0 !== (m_mode == MRun)) begin bad++; $display("FAIL rand_running: got %b want %b", run0, m_mode == MRun); end
      total++; if (exp0 !== m_exp) begin bad++; $display("FAIL rand_expires: got %b want %b", exp0, m_exp); end
      total++; if (pls0 !== m_pulse) begin bad++; $display("FAIL rand_pulse: got %b want %b", pls0, m_pulse); end
      total++; if (warn0 !== (!up0 && (m_val <= bcd_val(wv0)))) begin
        bad++; $display("FAIL rand_warning: got %b want %b", warn0, !up0 && (m_val <= bcd_val(wv0)));
      end
      en0  = ($urandom_range(0, 9) != 0);
      clr0 = ($urandom_range(0, 99) < 2);
      ld0  = ($urandom_range(0, 99) < 4);
      lv0  = {24'h0, 8'($urandom)};
      wv0  = {24'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 99) < 3) up0 = ~up0;
    end
  endtask

  initial begin
    reset = 1'b1;
    en0 = 1'b0; clr0 = 1'b0; ld0 = 1'b0; up0 = 1'b0; lv0 = '0; wv0 = '0;
    en1 = 1'b0; clr1 = 1'b0; ld1 = 1'b0; up1 = 1'b0; lv1 = '0; wv1 = '0;
    model_reset();
    #12;
    reset = 1'b0;
    test_reset();
    test_expire();
    test_borrow();
    test_pause();
    test_wrap();
    test_clear_load();
    test_warning();
    test_load_terminal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
